// File: rtl/sd_spi_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_cmd_master
//  Description : Host-side SD-card SPI command engine. Builds the 48-bit
//                command frame (with CRC7), shifts it out in SPI mode 0,
//                then polls with 0xFF bytes until an R1 response arrives
//                or the poll-byte budget runs out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_cmd_master #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        resp_timeout,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_TC  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]         c_TIMEOUT = 8'(RESP_TIMEOUT);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_POLL = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state_q,        w_state_d;
    logic [c_DIV_W-1:0] r_div_q,          w_div_d;
    logic               r_sclk_q,         w_sclk_d;
    logic               r_mosi_q,         w_mosi_d;
    logic               r_cs_n_q,         w_cs_n_d;
    logic [47:0]        r_frame_q,        w_frame_d;
    logic [5:0]         r_bit_cnt_q,      w_bit_cnt_d;
    logic [7:0]         r_rx_q,           w_rx_d;
    logic [7:0]         r_poll_cnt_q,     w_poll_cnt_d;
    logic [7:0]         r_resp_data_q,    w_resp_data_d;
    logic               r_resp_timeout_q, w_resp_timeout_d;

    logic        w_active, w_tick, w_rise, w_fall, w_accept;
    logic        w_send_end, w_byte_end, w_got_resp, w_timeout;
    logic [7:0]  w_poll_next;
    logic [39:0] w_head;

    // CRC7 (x^7 + x^3 + 1), bit-serial over the 40 header bits, MSB first
    function automatic logic [6:0] f_crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    assign w_head      = {2'b01, cmd_index, cmd_arg};
    assign w_active    = (r_state_q == c_ST_SEND) || (r_state_q == c_ST_POLL);
    assign w_tick      = w_active && (r_div_q == c_DIV_TC);
    assign w_rise      = w_tick && !r_sclk_q;
    assign w_fall      = w_tick &&  r_sclk_q;
    assign w_accept    = cmd_valid && (r_state_q == c_ST_IDLE);
    assign w_send_end  = (r_state_q == c_ST_SEND) && w_fall && (r_bit_cnt_q == 6'd47);
    // A poll byte is judged on the falling edge that follows its 8th rise
    assign w_byte_end  = (r_state_q == c_ST_POLL) && w_fall && (r_bit_cnt_q == 6'd8);
    assign w_got_resp  = !r_rx_q[7];
    assign w_poll_next = r_poll_cnt_q + 8'd1;
    assign w_timeout   = (w_poll_next == c_TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state_q <= c_ST_IDLE;
        else     r_state_q <= w_state_d;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: if (w_accept)   w_state_d = c_ST_SEND;
            c_ST_SEND: if (w_send_end) w_state_d = c_ST_POLL;
            c_ST_POLL: if (w_byte_end && (w_got_resp || w_timeout)) w_state_d = c_ST_DONE;
            c_ST_DONE: w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    // Datapath next values: divider, SPI pins, shift registers, result
    always_comb begin
        w_div_d          = r_div_q;
        w_sclk_d         = r_sclk_q;
        w_mosi_d         = r_mosi_q;
        w_cs_n_d         = r_cs_n_q;
        w_frame_d        = r_frame_q;
        w_bit_cnt_d      = r_bit_cnt_q;
        w_rx_d           = r_rx_q;
        w_poll_cnt_d     = r_poll_cnt_q;
        w_resp_data_d    = r_resp_data_q;
        w_resp_timeout_d = r_resp_timeout_q;

        if (w_active) begin
            w_div_d = w_tick ? '0 : r_div_q + 1'b1;
            if (w_tick) w_sclk_d = ~r_sclk_q;
        end

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_frame_d        = {w_head, f_crc7(w_head), 1'b1};
                    w_mosi_d         = w_head[39];
                    w_cs_n_d         = 1'b0;
                    w_sclk_d         = 1'b0;
                    w_div_d          = '0;
                    w_bit_cnt_d      = '0;
                    w_poll_cnt_d     = '0;
                    w_rx_d           = '0;
                    w_resp_timeout_d = 1'b0;
                end
            end
            c_ST_SEND: begin
                if (w_fall) begin
                    if (r_bit_cnt_q == 6'd47) begin
                        w_mosi_d    = 1'b1;
                        w_bit_cnt_d = '0;
                    end else begin
                        w_mosi_d    = r_frame_q[46];
                        w_frame_d   = {r_frame_q[46:0], 1'b0};
                        w_bit_cnt_d = r_bit_cnt_q + 6'd1;
                    end
                end
            end
            c_ST_POLL: begin
                if (w_rise) begin
                    w_rx_d      = {r_rx_q[6:0], miso};
                    w_bit_cnt_d = r_bit_cnt_q + 6'd1;
                end else if (w_byte_end) begin
                    w_bit_cnt_d = '0;
                    if (w_got_resp) begin
                        w_resp_data_d = r_rx_q;
                        w_cs_n_d      = 1'b1;
                    end else if (w_timeout) begin
                        w_resp_data_d    = 8'hFF;
                        w_resp_timeout_d = 1'b1;
                        w_cs_n_d         = 1'b1;
                    end else begin
                        w_poll_cnt_d = w_poll_next;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q          <= '0;
            r_sclk_q         <= 1'b0;
            r_mosi_q         <= 1'b1;
            r_cs_n_q         <= 1'b1;
            r_frame_q        <= '0;
            r_bit_cnt_q      <= '0;
            r_rx_q           <= '0;
            r_poll_cnt_q     <= '0;
            r_resp_data_q    <= 8'hFF;
            r_resp_timeout_q <= 1'b0;
        end else begin
            r_div_q          <= w_div_d;
            r_sclk_q         <= w_sclk_d;
            r_mosi_q         <= w_mosi_d;
            r_cs_n_q         <= w_cs_n_d;
            r_frame_q        <= w_frame_d;
            r_bit_cnt_q      <= w_bit_cnt_d;
            r_rx_q           <= w_rx_d;
            r_poll_cnt_q     <= w_poll_cnt_d;
            r_resp_data_q    <= w_resp_data_d;
            r_resp_timeout_q <= w_resp_timeout_d;
        end
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready  = (r_state_q == c_ST_IDLE);
        busy       = (r_state_q != c_ST_IDLE);
        resp_valid = (r_state_q == c_ST_DONE);
    end

    assign sclk         = r_sclk_q;
    assign mosi         = r_mosi_q;
    assign cs_n         = r_cs_n_q;
    assign resp_data    = r_resp_data_q;
    assign resp_timeout = r_resp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_cmd_master
//  Description : Self-checking bench for sd_spi_cmd_master. Two instances
//                (CLK_DIV=4 and CLK_DIV=1) each talk to a behavioural card
//                that captures the command frame and returns a scripted
//                sequence of poll bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_cmd_master;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst        [2] = '{1'b1, 1'b1};
    logic        cmd_valid  [2] = '{1'b0, 1'b0};
    logic [5:0]  cmd_index  [2] = '{6'd0, 6'd0};
    logic [31:0] cmd_arg    [2] = '{32'd0, 32'd0};
    logic        miso       [2] = '{1'b1, 1'b1};
    logic        cmd_ready  [2];
    logic        resp_valid [2];
    logic [7:0]  resp_data  [2];
    logic        resp_timeout [2];
    logic        busy       [2];
    logic        sclk       [2];
    logic        mosi       [2];
    logic        cs_n       [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sd_spi_cmd_master #(.CLK_DIV(4), .RESP_TIMEOUT(c_TO)) u_dut_div4 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_index(cmd_index[0]), .cmd_arg(cmd_arg[0]), .resp_valid(resp_valid[0]),
        .resp_data(resp_data[0]), .resp_timeout(resp_timeout[0]), .busy(busy[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]), .cs_n(cs_n[0])
    );

    sd_spi_cmd_master #(.CLK_DIV(1), .RESP_TIMEOUT(c_TO)) u_dut_div1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_index(cmd_index[1]), .cmd_arg(cmd_arg[1]), .resp_valid(resp_valid[1]),
        .resp_data(resp_data[1]), .resp_timeout(resp_timeout[1]), .busy(busy[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]), .cs_n(cs_n[1])
    );

    // ---------------- card model and bus monitors ----------------
    logic [7:0] poll_byte [2][0:15];
    bit         mosi_bits [2][0:255];
    int cyc = 0;
    int n_acc[2]      = '{0, 0};
    int acc_cyc[2]    = '{0, 0};
    int n_resp[2]     = '{0, 0};
    int rv_cyc[2]     = '{0, 0};
    int nrise[2]      = '{0, 0};
    int last_rises[2] = '{0, 0};
    int sclk_viol[2]  = '{0, 0};
    int mosi_viol[2]  = '{0, 0};
    logic prev_sclk[2] = '{1'b0, 1'b0};
    logic prev_mosi[2] = '{1'b1, 1'b1};
    logic prev_cs_n[2] = '{1'b1, 1'b1};

    function automatic int cdiv(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // Bit the card presents before rise number n (0-based) of a transaction
    function automatic logic card_bit(input int u, input int n);
        int p;
        if (n < 48) return logic'(n % 2);
        p = (n - 48) / 8;
        if (p > 15) return 1'b1;
        return poll_byte[u][p][7 - ((n - 48) % 8)];
    endfunction

    // Reference CRC7 as GF(2) polynomial remainder of header*x^7 mod 0x89
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [7:0] cap_byte(input int u, input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7 - i] = mosi_bits[u][8 * b + i];
        return v;
    endfunction

    // Handshake and response event log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (!rst[u] && cmd_valid[u] && cmd_ready[u]) begin
                n_acc[u]   <= n_acc[u] + 1;
                acc_cyc[u] <= cyc;
            end
            if (!rst[u] && resp_valid[u]) begin
                n_resp[u] <= n_resp[u] + 1;
                rv_cyc[u] <= cyc;
            end
        end
    end

    // SPI bus sampling, frame capture and miso generation
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cs_n[u]) begin
                if (!prev_cs_n[u]) last_rises[u] <= nrise[u];
                if (sclk[u]) sclk_viol[u] <= sclk_viol[u] + 1;
                nrise[u] <= 0;
                miso[u]  <= card_bit(u, 0);
            end else if (sclk[u] && !prev_sclk[u]) begin
                if (nrise[u] < 256) mosi_bits[u][nrise[u]] <= mosi[u];
                if (mosi[u] !== prev_mosi[u]) mosi_viol[u] <= mosi_viol[u] + 1;
                nrise[u] <= nrise[u] + 1;
                miso[u]  <= card_bit(u, nrise[u] + 1);
            end else begin
                miso[u]  <= card_bit(u, nrise[u]);
            end
            prev_sclk[u] <= sclk[u];
            prev_mosi[u] <= mosi[u];
            prev_cs_n[u] <= cs_n[u];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input int u);
        chk("idle_cs_n", 64'(cs_n[u]), 64'd1);
        chk("idle_sclk", 64'(sclk[u]), 64'd0);
        chk("idle_mosi", 64'(mosi[u]), 64'd1);
        chk("idle_busy", 64'(busy[u]), 64'd0);
        chk("idle_resp_valid", 64'(resp_valid[u]), 64'd0);
        chk("idle_cmd_ready", 64'(cmd_ready[u]), 64'd1);
    endtask

    // One command: k = poll byte carrying the R1 (1-based), 0 = card never answers.
    // hold keeps cmd_valid high with another index after the accept.
    task automatic do_cmd(input int u, input logic [5:0] idx, input logic [31:0] arg,
                          input int k, input logic [7:0] rbyte, input bit junk, input bit hold);
        int base_acc, base_resp, base_sv, base_mv, kexp, ref_lat, lat, guard, zeros, cs_glitch, rdy_seen;
        logic [39:0] head;
        logic [47:0] frame;
        logic [7:0]  exp_data;

        for (int p = 0; p < 16; p++) begin
            if (k != 0 && p == k - 1) poll_byte[u][p] = rbyte;
            else if (junk)            poll_byte[u][p] = 8'h80 | 8'($urandom);
            else                      poll_byte[u][p] = 8'hFF;
        end
        kexp     = (k == 0) ? c_TO : k;
        exp_data = (k == 0) ? 8'hFF : rbyte;
        head     = {2'b01, idx, arg};
        frame    = {head, crc7_ref(head), 1'b1};
        ref_lat  = (48 + 8 * kexp) * 2 * cdiv(u);

        guard = 0;
        while (!cmd_ready[u] && guard < 5000) begin @(negedge clk); guard++; end
        chk("ready_wait", 64'(cmd_ready[u]), 64'd1);

        base_acc = n_acc[u]; base_resp = n_resp[u];
        base_sv = sclk_viol[u]; base_mv = mosi_viol[u];
        cmd_index[u] = idx; cmd_arg[u] = arg; cmd_valid[u] = 1'b1;
        @(negedge clk);
        chk("accept", 64'(n_acc[u] - base_acc), 64'd1);
        chk("acc_cs_n", 64'(cs_n[u]), 64'd0);
        chk("acc_mosi", 64'(mosi[u]), 64'(frame[47]));
        chk("acc_sclk", 64'(sclk[u]), 64'd0);
        chk("acc_ready", 64'(cmd_ready[u]), 64'd0);
        if (hold) cmd_index[u] = idx ^ 6'h15;
        else      cmd_valid[u] = 1'b0;

        guard = 0; cs_glitch = 0; rdy_seen = 0;
        while (!resp_valid[u] && guard < ref_lat + 100) begin
            @(negedge clk);
            guard++;
            if (!resp_valid[u] && cs_n[u])      cs_glitch++;
            if (!resp_valid[u] && cmd_ready[u]) rdy_seen++;
        end
        if (!resp_valid[u]) begin
            chk("resp_wait", 64'd0, 64'd1);
            return;
        end
        chk("resp_data", 64'(resp_data[u]), 64'(exp_data));
        chk("resp_timeout", 64'(resp_timeout[u]), 64'(k == 0));
        chk("done_cs_n", 64'(cs_n[u]), 64'd1);
        chk("done_sclk", 64'(sclk[u]), 64'd0);
        chk("done_mosi", 64'(mosi[u]), 64'd1);
        chk("done_busy", 64'(busy[u]), 64'd1);
        chk("cs_continuous", 64'(cs_glitch), 64'd0);
        chk("ready_while_busy", 64'(rdy_seen), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("resp_pulses", 64'(n_resp[u] - base_resp), 64'd1);
        chk("accept_count", 64'(n_acc[u] - base_acc), 64'd1);
        lat = rv_cyc[u] - acc_cyc[u];
        chk("latency_in_window", 64'(lat >= ref_lat && lat <= ref_lat + 2), 64'd1);
        chk("sclk_rises", 64'(last_rises[u]), 64'(48 + 8 * kexp));
        for (int b = 0; b < 6; b++) chk("frame_byte", 64'(cap_byte(u, b)), 64'(frame[47 - 8 * b -: 8]));
        zeros = 0;
        for (int i = 48; i < last_rises[u] && i < 256; i++) if (!mosi_bits[u][i]) zeros++;
        chk("poll_mosi_ones", 64'(zeros), 64'd0);
        chk("sclk_while_cs_high", 64'(sclk_viol[u] - base_sv), 64'd0);
        chk("mosi_stable_on_rise", 64'(mosi_viol[u] - base_mv), 64'd0);
    endtask

    task automatic reset_mid(input int u);
        int guard, base_resp;
        for (int p = 0; p < 16; p++) poll_byte[u][p] = 8'h01;
        cmd_index[u] = 6'd0; cmd_arg[u] = 32'd0; cmd_valid[u] = 1'b1;
        @(negedge clk);
        cmd_valid[u] = 1'b0;
        guard = 0;
        while (nrise[u] < 20 && guard < 1000) begin @(negedge clk); guard++; end
        chk("reach_bit20", 64'(nrise[u] >= 20), 64'd1);
        base_resp = n_resp[u];
        rst[u] = 1'b1;
        @(negedge clk);
        chk_idle(u);
        rst[u] = 1'b0;
        repeat (1000) @(negedge clk);
        chk("no_resp_after_abort", 64'(n_resp[u] - base_resp), 64'd0);
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog: got=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk_idle(u);
            chk("reset_resp_data", 64'(resp_data[u]), 64'hFF);
            chk("reset_resp_timeout", 64'(resp_timeout[u]), 64'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            do_cmd(u, 6'd0, 32'h0000_0000, 2, 8'h01, 1'b0, 1'b0);
            chk("cmd0_crc_byte", 64'(cap_byte(u, 5)), 64'h95);
            do_cmd(u, 6'd8, 32'h0000_01AA, 1, 8'h01, 1'b0, 1'b0);
            chk("cmd8_crc_byte", 64'(cap_byte(u, 5)), 64'h87);
            do_cmd(u, 6'd17, $urandom, 0, 8'h00, 1'b0, 1'b0);
            do_cmd(u, 6'd55, 32'hDEAD_BEEF, 1, 8'h00, 1'b1, 1'b1);
            do_cmd(u, 6'd55 ^ 6'h15, 32'hDEAD_BEEF, 3, 8'h05, 1'b1, 1'b0);
            reset_mid(u);
            do_cmd(u, 6'd0, 32'h0000_0000, 1, 8'h01, 1'b0, 1'b0);
            for (int t = 0; t < 6; t++)
                do_cmd(u, 6'($urandom_range(0, 63)), $urandom, $urandom_range(0, c_TO),
                       8'($urandom_range(0, 127)), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
